// File: rtl/key_lut_pkg.sv
// key_lut_pkg: shared constants, width helpers and the table entry type for key_lut_cam.
//   ptr_width(nr) : bits needed to index nr table entries (at least 1)
//   cnt_width(nr) : bits needed to hold a count of 0..nr
//   entry_t       : one table slot {valid, key, data}. Key and data fields are sized for the
//                   widest supported configuration (64 bits). Narrower instances store
//                   zero-extended values, and synthesis removes the constant upper bits.
package key_lut_pkg;

  localparam int unsigned KeyMaxLen  = 64;
  localparam int unsigned DataMaxLen = 64;

  function automatic int unsigned ptr_width(int unsigned nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned nr);
    return $clog2(nr + 1);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [KeyMaxLen-1:0]  key;
    logic [DataMaxLen-1:0] data;
  } entry_t;

endpackage

// File: rtl/key_lut_prienc.sv
// key_lut_prienc: lowest-index priority encoder.
//   req_i : N request bits
//   idx_o : index of the lowest set bit in req_i (0 when none is set)
//   any_o : high when at least one bit of req_i is set
module key_lut_prienc
  import key_lut_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = ptr_width(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_lut_cam.sv
// key_lut_cam: small fully-associative key -> data lookup table.
//   clk, rst                  : clock and synchronous active-high reset
//   wr_en/wr_key/wr_data      : insert a new key or update the data of an existing key
//   del_en/del_key            : remove the entry holding del_key (no-op on a miss)
//   flush                     : invalidate every entry (wins over write and delete)
//   lk_valid/lk_key/lk_ready  : lookup request handshake
//   default_out               : data returned on a miss, captured with the lookup
//   rsp_valid/rsp_hit/rsp_data/rsp_ready : registered lookup response handshake
//   count/full                : number of valid entries, and count == NR_KEY
// When the table is full a new key overwrites the slot at a round-robin replacement pointer.
module key_lut_cam
  import key_lut_pkg::*;
#(
  parameter int unsigned NR_KEY      = 4,
  parameter int unsigned KEY_LEN     = 4,
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned HAS_DEFAULT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [KEY_LEN-1:0]            wr_key,
  input  logic [DATA_LEN-1:0]           wr_data,
  input  logic                          del_en,
  input  logic [KEY_LEN-1:0]            del_key,
  input  logic                          flush,
  input  logic                          lk_valid,
  input  logic [KEY_LEN-1:0]            lk_key,
  output logic                          lk_ready,
  input  logic [DATA_LEN-1:0]           default_out,
  output logic                          rsp_valid,
  output logic                          rsp_hit,
  output logic [DATA_LEN-1:0]           rsp_data,
  input  logic                          rsp_ready,
  output logic [cnt_width(NR_KEY)-1:0]  count,
  output logic                          full
);

  localparam int unsigned PtrW = ptr_width(NR_KEY);
  localparam int unsigned CntW = cnt_width(NR_KEY);

  entry_t               tbl_q [NR_KEY];
  entry_t               tbl_d [NR_KEY];
  logic [PtrW-1:0]      rp_q, rp_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [DATA_LEN-1:0]  rsp_data_q, rsp_data_d;

  logic [KeyMaxLen-1:0]  lk_key_x, wr_key_x, del_key_x;
  logic [DataMaxLen-1:0] wr_data_x, hit_data_full;
  logic [NR_KEY-1:0]     lk_match, wr_match, del_match, free_vec;
  logic [PtrW-1:0]       lk_idx, wr_idx, del_idx, free_idx, wr_tgt;
  logic                  lk_any, wr_any, del_any, free_any;
  logic                  lk_acc, del_eff;
  logic                  unused_hit_data;

  assign lk_key_x  = KeyMaxLen'(lk_key);
  assign wr_key_x  = KeyMaxLen'(wr_key);
  assign del_key_x = KeyMaxLen'(del_key);
  assign wr_data_x = DataMaxLen'(wr_data);

  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      lk_match[i]  = tbl_q[i].valid && (tbl_q[i].key == lk_key_x);
      wr_match[i]  = tbl_q[i].valid && (tbl_q[i].key == wr_key_x);
      del_match[i] = tbl_q[i].valid && (tbl_q[i].key == del_key_x);
      free_vec[i]  = !tbl_q[i].valid;
    end
  end

  key_lut_prienc #(.N(NR_KEY)) u_lk_enc (.req_i(lk_match), .idx_o(lk_idx), .any_o(lk_any));
  key_lut_prienc #(.N(NR_KEY)) u_wr_enc (.req_i(wr_match), .idx_o(wr_idx), .any_o(wr_any));
  key_lut_prienc #(.N(NR_KEY)) u_del_enc (.req_i(del_match), .idx_o(del_idx), .any_o(del_any));
  key_lut_prienc #(.N(NR_KEY)) u_free_enc (.req_i(free_vec), .idx_o(free_idx), .any_o(free_any));

  assign lk_ready = !rsp_valid_q || rsp_ready;
  assign lk_acc   = lk_valid && lk_ready;

  // Only the low DATA_LEN bits of a stored entry are ever non-zero.
  assign hit_data_full   = tbl_q[lk_idx].data;
  assign unused_hit_data = ^hit_data_full;

  // Response register: lookup sees the table as it was before this edge's writes.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_data_d  = rsp_data_q;
    if (lk_acc) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = lk_any;
      if (lk_any) begin
        rsp_data_d = hit_data_full[DATA_LEN-1:0];
      end else begin
        rsp_data_d = (HAS_DEFAULT != 0) ? default_out : '0;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // A delete of the key being written in the same cycle is dropped.
  assign del_eff = del_en && del_any && !(wr_en && (wr_key == del_key));

  // Slot for a new key: first free slot, else the replacement pointer (pre-edge state).
  assign wr_tgt = free_any ? free_idx : rp_q;

  always_comb begin
    tbl_d = tbl_q;
    rp_d  = rp_q;
    if (flush) begin
      for (int i = 0; i < NR_KEY; i++) begin
        tbl_d[i].valid = 1'b0;
      end
      rp_d = '0;
    end else begin
      if (del_eff) begin
        tbl_d[del_idx].valid = 1'b0;
      end
      // Applied after the delete: if a full-table replacement lands on the slot being
      // deleted, the new key wins and the slot stays valid.
      if (wr_en) begin
        if (wr_any) begin
          tbl_d[wr_idx].data = wr_data_x;
        end else begin
          tbl_d[wr_tgt] = '{valid: 1'b1, key: wr_key_x, data: wr_data_x};
          if (!free_any) begin
            rp_d = (rp_q == PtrW'(NR_KEY - 1)) ? '0 : rp_q + PtrW'(1);
          end
        end
      end
    end
    // Count tracks the valid bits exactly, which keeps corner cases self-consistent.
    count_d = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      count_d = count_d + CntW'(tbl_d[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_KEY; i++) begin
        tbl_q[i] <= '0;
      end
      rp_q        <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      tbl_q       <= tbl_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign full      = (count_q == CntW'(NR_KEY));

endmodule
